// File: rtl/vga_pkg.sv
// Shared VGA geometry plus the projectile controller's state and sector encodings.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    typedef enum logic [1:0] {
        PROJ_IDLE,
        PROJ_FLY,
        PROJ_COOLDOWN
    } proj_state_t;

    // Sector numbering runs counter-clockwise from "right", y up positive.
    localparam logic [2:0] SEC_R  = 3'd0;
    localparam logic [2:0] SEC_UR = 3'd1;
    localparam logic [2:0] SEC_U  = 3'd2;
    localparam logic [2:0] SEC_UL = 3'd3;
    localparam logic [2:0] SEC_L  = 3'd4;
    localparam logic [2:0] SEC_DL = 3'd5;
    localparam logic [2:0] SEC_D  = 3'd6;
    localparam logic [2:0] SEC_DR = 3'd7;

endpackage

// File: rtl/archer_dir_sector.sv
// Quantises the archer-to-cursor vector into one of eight 45-degree sectors.
module archer_dir_sector
    import vga_pkg::*;
(
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    output logic [2:0]  direction_sector
);

    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic        [13:0] abs_dx;
    logic        [13:0] abs_dy;

    assign dx     = $signed({1'b0, mouse_x}) - $signed({1'b0, char_x});
    assign dy     = $signed({1'b0, char_y}) - $signed({1'b0, mouse_y});
    assign abs_dx = {1'b0, (dx[12] ? -dx : dx)};
    assign abs_dy = {1'b0, (dy[12] ? -dy : dy)};

    // Doubling stays inside 14 bits because each magnitude is at most 4095.
    always_comb begin
        direction_sector = SEC_R;
        if (abs_dx >= {abs_dy[12:0], 1'b0}) begin
            direction_sector = dx[12] ? SEC_L : SEC_R;
        end else if (abs_dy >= {abs_dx[12:0], 1'b0}) begin
            direction_sector = dy[12] ? SEC_D : SEC_U;
        end else begin
            unique case ({dx[12], dy[12]})
                2'b00:   direction_sector = SEC_UR;
                2'b10:   direction_sector = SEC_UL;
                2'b11:   direction_sector = SEC_DL;
                default: direction_sector = SEC_DR;
            endcase
        end
    end

endmodule

// File: rtl/archer_projectile_ctl.sv
// Archer projectile launcher: click edge fires one shot, vsync edge advances it each frame,
// it retires at the screen edge or when its range expires, then a cooldown gates the next shot.
module archer_projectile_ctl
    import vga_pkg::*;
#(
    parameter int PROJ_SPEED      = 8,
    parameter int DIAG_SPEED      = 6,
    parameter int MAX_FRAMES      = 90,
    parameter int COOLDOWN_FRAMES = 20,
    parameter int PROJ_HALF       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [1:0]  game_active,
    input  logic        mouse_clicked,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    output logic [11:0] pos_x_proj,
    output logic [11:0] pos_y_proj,
    output logic        projectile_active,
    output logic        projectile_animated,
    output logic [2:0]  direction_sector
);

    localparam int FRAME_W = $clog2(MAX_FRAMES + 1);
    localparam int CD_W    = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic signed [13:0] V_STR     = 14'(PROJ_SPEED);
    localparam logic signed [13:0] V_DIAG    = 14'(DIAG_SPEED);
    localparam logic signed [13:0] EDGE_LO   = 14'(PROJ_HALF);
    localparam logic signed [13:0] EDGE_HI_X = 14'(HOR_PIXELS - 1 - PROJ_HALF);
    localparam logic signed [13:0] EDGE_HI_Y = 14'(VER_PIXELS - 1 - PROJ_HALF);

    proj_state_t          state_q, state_d;
    logic [11:0]          pos_x_q, pos_x_d;
    logic [11:0]          pos_y_q, pos_y_d;
    logic [2:0]           sector_q, sector_d;
    logic                 animated_q, animated_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CD_W-1:0]      cd_cnt_q, cd_cnt_d;
    logic                 click_q;
    logic                 vsync_q;

    logic                 click_rise;
    logic                 tick;
    logic [2:0]           launch_sector;
    logic signed [13:0]   vel_x, vel_y;
    logic signed [13:0]   next_x, next_y;
    logic                 edge_hit;
    logic                 range_done;

    archer_dir_sector u_dir_sector (
        .mouse_x          (mouse_x),
        .mouse_y          (mouse_y),
        .char_x           (char_x),
        .char_y           (char_y),
        .direction_sector (launch_sector)
    );

    assign click_rise = mouse_clicked & ~click_q;
    assign tick       = vsync & ~vsync_q;

    // Screen y grows downward, so "up" sectors carry a negative y velocity.
    always_comb begin
        vel_x = '0;
        vel_y = '0;
        unique case (sector_q)
            SEC_R:   begin vel_x =  V_STR;                       end
            SEC_UR:  begin vel_x =  V_DIAG; vel_y = -V_DIAG;     end
            SEC_U:   begin                  vel_y = -V_STR;      end
            SEC_UL:  begin vel_x = -V_DIAG; vel_y = -V_DIAG;     end
            SEC_L:   begin vel_x = -V_STR;                       end
            SEC_DL:  begin vel_x = -V_DIAG; vel_y =  V_DIAG;     end
            SEC_D:   begin                  vel_y =  V_STR;      end
            default: begin vel_x =  V_DIAG; vel_y =  V_DIAG;     end
        endcase
    end

    // Signed next position lets a step past x=0 read as negative instead of wrapping.
    assign next_x     = $signed({2'b00, pos_x_q}) + vel_x;
    assign next_y     = $signed({2'b00, pos_y_q}) + vel_y;
    assign edge_hit   = (next_x < EDGE_LO) || (next_x > EDGE_HI_X) ||
                        (next_y < EDGE_LO) || (next_y > EDGE_HI_Y);
    assign range_done = (frame_cnt_q + FRAME_W'(1)) == FRAME_W'(MAX_FRAMES);

    // NOTE: every _d gets its hold value first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        sector_d    = sector_q;
        animated_d  = animated_q;
        frame_cnt_d = frame_cnt_q;
        cd_cnt_d    = cd_cnt_q;

        if (game_active == 2'd0) begin
            state_d     = PROJ_IDLE;
            pos_x_d     = '0;
            pos_y_d     = '0;
            sector_d    = SEC_R;
            animated_d  = 1'b0;
            frame_cnt_d = '0;
            cd_cnt_d    = '0;
        end else begin
            unique case (state_q)
                PROJ_IDLE: begin
                    if (click_rise) begin
                        state_d     = PROJ_FLY;
                        pos_x_d     = char_x;
                        pos_y_d     = char_y;
                        sector_d    = launch_sector;
                        animated_d  = 1'b0;
                        frame_cnt_d = '0;
                    end
                end
                PROJ_FLY: begin
                    if (tick) begin
                        if (edge_hit || range_done) begin
                            state_d    = PROJ_COOLDOWN;
                            animated_d = 1'b0;
                            cd_cnt_d   = '0;
                        end else begin
                            pos_x_d     = next_x[11:0];
                            pos_y_d     = next_y[11:0];
                            animated_d  = 1'b1;
                            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                        end
                    end
                end
                PROJ_COOLDOWN: begin
                    if (tick) begin
                        if ((cd_cnt_q + CD_W'(1)) == CD_W'(COOLDOWN_FRAMES)) begin
                            state_d  = PROJ_IDLE;
                            cd_cnt_d = '0;
                        end else begin
                            cd_cnt_d = cd_cnt_q + CD_W'(1);
                        end
                    end
                end
                default: state_d = PROJ_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PROJ_IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            sector_q    <= SEC_R;
            animated_q  <= 1'b0;
            frame_cnt_q <= '0;
            cd_cnt_q    <= '0;
            click_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            sector_q    <= sector_d;
            animated_q  <= animated_d;
            frame_cnt_q <= frame_cnt_d;
            cd_cnt_q    <= cd_cnt_d;
            click_q     <= mouse_clicked;
            vsync_q     <= vsync;
        end
    end

    assign pos_x_proj          = pos_x_q;
    assign pos_y_proj          = pos_y_q;
    assign projectile_active   = (state_q == PROJ_FLY);
    assign projectile_animated = animated_q;
    assign direction_sector    = sector_q;

endmodule

// File: tb/tb_archer_projectile_ctl.sv
// Scenario bench for archer_projectile_ctl: expectations queued at stimulus time, popped and compared on output.
module tb_archer_projectile_ctl;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [1:0]  game_active;
    logic        mouse_clicked;
    logic [11:0] mouse_x, mouse_y, char_x, char_y;
    logic [11:0] pos_x_proj, pos_y_proj;
    logic        projectile_active, projectile_animated;
    logic [2:0]  direction_sector;

    archer_projectile_ctl #(.MAX_FRAMES(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .vsync               (vsync),
        .game_active         (game_active),
        .mouse_clicked       (mouse_clicked),
        .mouse_x             (mouse_x),
        .mouse_y             (mouse_y),
        .char_x              (char_x),
        .char_y              (char_y),
        .pos_x_proj          (pos_x_proj),
        .pos_y_proj          (pos_y_proj),
        .projectile_active   (projectile_active),
        .projectile_animated (projectile_animated),
        .direction_sector    (direction_sector)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [28:0] val;
        logic [28:0] mask;
    } exp_t;

    localparam logic [28:0] M_ALL = {29{1'b1}};
    localparam logic [28:0] M_FLG = {24'h0, 2'b11, 3'b000};
    localparam logic [28:0] M_SEC = {26'h0, 3'b111};

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Sector table: offsets from the archer (y up positive) and the hand-derived sector.
    int tdx  [12] = '{100, 100, 100,   0, -30, -100, -100, -100,    0,   60, 0, -100};
    int tdy  [12] = '{  0,  50,  60, 100, 100,  100,    0,  -60, -100, -100, 0,  -50};
    int tsec [12] = '{  0,   0,   1,   2,   2,    3,    4,    5,    6,    7, 0,    4};

    function automatic logic [28:0] obs();
        return {pos_x_proj, pos_y_proj, projectile_active, projectile_animated, direction_sector};
    endfunction

    function automatic exp_t mk(string n, int x, int y, bit act, bit anim, int sec, logic [28:0] m);
        exp_t r;
        r.name = n;
        r.val  = {12'(x), 12'(y), act, anim, 3'(sec)};
        r.mask = m;
        return r;
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
        step(1);
    endtask

    task automatic press(int cx, int cy, int mx, int my);
        char_x = 12'(cx); char_y = 12'(cy);
        mouse_x = 12'(mx); mouse_y = 12'(my);
        mouse_clicked = 1'b1;
        step(1);
    endtask

    task automatic release_btn();
        mouse_clicked = 1'b0;
        step(1);
    endtask

    task automatic abort_flight();
        game_active = 2'd0; mouse_clicked = 1'b0; vsync = 1'b0;
        step(2);
        game_active = 2'd1;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; mouse_clicked = 1'b0; game_active = 2'd1;
        char_x = '0; char_y = '0; mouse_x = '0; mouse_y = '0;
        step(3);
        rst = 1'b0;
        sb.push_back(mk("reset_state", 0, 0, 0, 0, 0, M_ALL));
        step(1);
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
    endtask

    task automatic test_straight();
        press(500, 400, 700, 400);
        sb.push_back(mk("launch_latency", 500, 400, 1, 0, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        release_btn();
        tick();
        sb.push_back(mk("first_move", 508, 400, 1, 1, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        tick(); tick();
        sb.push_back(mk("three_moves", 524, 400, 1, 1, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        abort_flight();
    endtask

    task automatic test_diagonal();
        press(500, 400, 400, 300);
        release_btn();
        tick(); tick();
        sb.push_back(mk("diag_ul", 488, 388, 1, 1, 3, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        abort_flight();
    endtask

    task automatic test_sectors();
        for (int i = 0; i < 12; i++) begin
            press(500, 400, 500 + tdx[i], 400 - tdy[i]);
            sb.push_back(mk($sformatf("sector_%0d", i), 0, 0, 1, 0, tsec[i], M_SEC | M_FLG));
            e = sb.pop_front(); checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
            release_btn();
            abort_flight();
        end
    endtask

    task automatic test_edge_retire();
        press(1000, 400, 1100, 400);
        release_btn();
        tick();
        sb.push_back(mk("edge_step1", 1008, 400, 1, 1, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        tick(); tick();
        sb.push_back(mk("edge_retire_hold", 1016, 400, 0, 0, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        abort_flight();
    endtask

    task automatic test_range_cooldown();
        press(500, 760, 500, 600);
        release_btn();
        repeat (4) tick();
        sb.push_back(mk("range_fly4", 500, 728, 1, 1, 2, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        tick();
        sb.push_back(mk("range_retire", 500, 728, 0, 0, 2, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 10 || i == 19) begin
                press(500, 760, 500, 600);
                sb.push_back(mk($sformatf("cooldown_click_%0d", i), 0, 0, 0, 0, 0, M_FLG));
                e = sb.pop_front(); checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
                release_btn();
            end
        end
        tick();
        press(500, 760, 500, 600);
        sb.push_back(mk("after_cooldown_fires", 500, 760, 1, 0, 2, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        release_btn();
        abort_flight();
    endtask

    task automatic test_held_button();
        press(500, 760, 500, 600);
        repeat (5) tick();
        sb.push_back(mk("held_retired", 0, 0, 0, 0, 0, M_FLG));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        repeat (20) tick();
        step(3);
        sb.push_back(mk("held_no_refire", 0, 0, 0, 0, 0, M_FLG));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        release_btn();
        press(500, 760, 500, 600);
        sb.push_back(mk("repress_fires", 0, 0, 1, 0, 0, M_FLG));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        release_btn();
        abort_flight();
    endtask

    task automatic test_simultaneous();
        char_x = 12'd300; char_y = 12'd300; mouse_x = 12'd400; mouse_y = 12'd300;
        mouse_clicked = 1'b1; vsync = 1'b1;
        step(1);
        sb.push_back(mk("simul_launch_only", 300, 300, 1, 0, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        mouse_clicked = 1'b0; vsync = 1'b0;
        step(2);
        tick();
        sb.push_back(mk("simul_first_move", 308, 300, 1, 1, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        abort_flight();
    endtask

    task automatic test_game_stop();
        press(500, 400, 700, 400);
        release_btn();
        tick();
        game_active = 2'd0;
        step(1);
        sb.push_back(mk("stop_clears", 0, 0, 0, 0, 0, M_FLG));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        press(500, 400, 700, 400);
        sb.push_back(mk("stopped_no_launch", 0, 0, 0, 0, 0, M_FLG));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        release_btn();
        game_active = 2'd2;
        step(1);
        press(500, 400, 700, 400);
        sb.push_back(mk("nonzero_active_fires", 500, 400, 1, 0, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        release_btn();
        abort_flight();
    endtask

    task automatic test_reset_mid_flight();
        press(500, 400, 400, 300);
        release_btn();
        tick();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb.push_back(mk("rst_mid_flight", 0, 0, 0, 0, 0, M_ALL));
        e = sb.pop_front(); checks++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s actual=%h required=%h", e.name, obs() & e.mask, e.val & e.mask); end
        step(1);
    endtask

    initial begin
        test_reset();
        test_straight();
        test_diagonal();
        test_sectors();
        test_edge_retire();
        test_range_cooldown();
        test_held_button();
        test_simultaneous();
        test_game_stop();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule
